// File: rtl/cgra_sram_streamer_pkg.sv
// Shared definitions for the CGRA SRAM burst streamer.
// Holds the controller state encoding, the data-path width and the
// byte-enable pattern used for every SRAM write. No ports.
package cgra_sram_streamer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam logic [3:0]  FULL_BE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    FINISH
  } state_e;

endpackage

// File: rtl/cgra_sram_streamer_if.sv
// Single-port SRAM request bus between the streamer and an SRAM wrapper.
// Signals:
//   req   - access request this cycle
//   we    - 1 = write, 0 = read
//   addr  - word address
//   wdata - write data
//   be    - byte enables (only meaningful on writes)
//   rdata - read data, valid the cycle after a read request
// Modports: master (streamer side), slave (SRAM side).
interface cgra_sram_streamer_if #(
  parameter int unsigned AddrWidth = 10
);
  import cgra_sram_streamer_pkg::*;

  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [DATA_W-1:0]    wdata;
  logic [3:0]           be;
  logic [DATA_W-1:0]    rdata;

  modport master (output req, we, addr, wdata, be, input rdata);
  modport slave  (input req, we, addr, wdata, be, output rdata);

endinterface

// File: rtl/cgra_sram_streamer_fifo.sv
// Two-entry fall-through FIFO that catches SRAM read data.
// A word pushed into an empty FIFO is visible on pop_data_o in the same
// cycle, so read data can leave the streamer the cycle it arrives.
// Ports:
//   clk_i, rst_ni       - clock, async active-low reset
//   push_i, push_data_i - write side
//   pop_i, pop_data_o   - read side (pop_data_o is the head word)
//   full_o, empty_o     - occupancy flags (empty_o accounts for bypass)
//   count_o             - number of stored words (excludes bypass)
module cgra_sram_streamer_fifo
  import cgra_sram_streamer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              bypass;
  logic              store;
  logic              drain;

  // A push into an empty FIFO that is popped in the same cycle never
  // touches storage; everything else is an ordinary store and/or drain.
  always_comb begin
    bypass     = (count_q == 2'd0) & push_i & pop_i;
    store      = push_i & ~bypass;
    drain      = pop_i & (count_q != 2'd0);
    count_d    = count_q + {1'b0, store} - {1'b0, drain};
    empty_o    = (count_q == 2'd0) & ~push_i;
    full_o     = (count_q == 2'd2);
    pop_data_o = (count_q == 2'd0) ? push_data_i : mem_q[rd_ptr_q];
    count_o    = count_q;
  end

  // Storage and pointers; reset discards any buffered words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (store) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (drain) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cgra_sram_streamer.sv
// Burst engine driving a single-port SRAM. One command at a time moves
// cmd_len_i words either from the in_* stream into SRAM (write mode) or
// from SRAM onto the out_* stream (read mode), starting at cmd_addr_i and
// wrapping modulo NumWords. The 1-cycle SRAM read latency is hidden by a
// 2-entry fall-through FIFO and a credit check on outstanding reads.
// Ports:
//   clk_i, rst_ni                       - clock, async active-low reset
//   cmd_valid_i/cmd_ready_o             - command handshake (ready in IDLE)
//   cmd_write_i, cmd_addr_i, cmd_len_i  - direction, start address, length
//   in_valid_i/in_ready_o, in_data_i    - write-data stream
//   out_valid_o/out_ready_i, out_data_o - read-data stream
//   sram                                - SRAM request bus (master side)
//   busy_o                              - burst in progress
//   done_o                              - one-cycle pulse when a burst ends
module cgra_sram_streamer
  import cgra_sram_streamer_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned LenWidth  = AddrWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_W-1:0]    in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_W-1:0]    out_data_o,
  cgra_sram_streamer_if.master sram,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  issued_q, issued_d;
  logic [LenWidth-1:0]  retired_q, retired_d;
  logic                 inflight_q, inflight_d;

  logic                 beat;
  logic                 room;
  logic                 out_fire;
  logic                 sram_req;
  logic                 sram_we;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [1:0]           fifo_count;

  // Read data lands here one cycle after each read request.
  cgra_sram_streamer_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight_q),
    .push_data_i (sram.rdata),
    .pop_i       (out_fire),
    .pop_data_o  (out_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // A new read may only go out if the word it returns is guaranteed a
  // FIFO slot: stored words plus the read still in flight must leave room.
  assign room        = ~fifo_full & (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);
  assign out_valid_o = ~fifo_empty;
  assign out_fire    = out_valid_o & out_ready_i;

  assign sram.req   = sram_req;
  assign sram.we    = sram_we;
  assign sram.addr  = addr_q;
  assign sram.wdata = in_data_i;
  assign sram.be    = FULL_BE;

  // Controller: decodes the state into port controls and computes the
  // next burst position. A "beat" is any SRAM access issued this cycle;
  // it advances the wrapping address and the issued count in both modes.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    retired_d   = retired_q;
    inflight_d  = 1'b0;
    cmd_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    sram_req    = 1'b0;
    sram_we     = 1'b0;
    beat        = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          addr_d    = cmd_addr_i;
          len_d     = cmd_len_i;
          issued_d  = '0;
          retired_d = '0;
          if (cmd_len_i == '0) begin
            state_d = FINISH;
          end else if (cmd_write_i) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        in_ready_o = 1'b1;
        sram_req   = in_valid_i;
        sram_we    = in_valid_i;
        beat       = in_valid_i;
        if (in_valid_i && (issued_q + LenWidth'(1) == len_q)) begin
          state_d = FINISH;
        end
      end
      READ: begin
        beat       = (issued_q != len_q) & room;
        sram_req   = beat;
        inflight_d = beat;
        if (out_fire && (retired_q + LenWidth'(1) == len_q)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (beat) begin
      addr_d   = (addr_q == LastAddr) ? '0 : addr_q + AddrWidth'(1);
      issued_d = issued_q + LenWidth'(1);
    end
    if (out_fire) begin
      retired_d = retired_q + LenWidth'(1);
    end
  end

  // State and counters; reset abandons any burst without a done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      inflight_q <= inflight_d;
    end
  end

  // A burst longer than the SRAM would revisit addresses; callers must
  // never request one.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cmd_valid_i && cmd_ready_o) |-> (cmd_len_i <= LenWidth'(NumWords)));

  // The credit check must keep every returning read word storable.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_q |-> !fifo_full);

endmodule

// File: tb/tb_cgra_sram_streamer.sv
// Self-checking bench for cgra_sram_streamer with a small SRAM (32 words)
// so address wrap is easy to reach. A behavioural SRAM answers the DUT's
// requests; a reference model predicts every SRAM access, every output
// word, the done pulse and the idle/busy handshakes cycle by cycle.
module tb_cgra_sram_streamer;

  localparam int NW = 32;
  localparam int AW = 5;
  localparam int LW = 6;

  logic          clk;
  logic          rst_ni;
  logic          cmd_valid;
  logic          cmd_ready_o;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          in_valid;
  logic          in_ready_o;
  logic [31:0]   in_data;
  logic          out_valid_o;
  logic          out_ready;
  logic [31:0]   out_data_o;
  logic          busy_o;
  logic          done_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] sramMem [NW];
  logic [31:0] sramRdata;
  logic [31:0] refMem [NW];
  logic [31:0] wdataArr [NW];
  logic [31:0] captured [$];

  cgra_sram_streamer_if #(.AddrWidth(AW)) sram_if ();

  cgra_sram_streamer #(.NumWords(NW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .out_data_o  (out_data_o),
    .sram        (sram_if),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  assign sram_if.rdata = sramRdata;

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seedWord(input int i);
    return 32'h1357_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic bit pickReady(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    return ((k % 4) == 0) || ((k % 4) == 3);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural single-port SRAM with one cycle of read latency.
  initial begin
    for (int i = 0; i < NW; i++) sramMem[i] = seedWord(i);
    sramRdata = '0;
    forever begin
      @(posedge clk);
      if (sram_if.req === 1'b1) begin
        if (sram_if.we) sramMem[sram_if.addr] = sram_if.wdata;
        else sramRdata <= sramMem[sram_if.addr];
      end
    end
  end

  // Reference model and per-cycle comparison. On acceptance the model
  // expands the command into the exact list of SRAM accesses it implies
  // and the exact words the output stream must carry; each cycle it then
  // checks the handshake outputs and consumes those lists as the DUT acts.
  initial begin
    logic [AW-1:0] qAddr [$];
    bit            qWe [$];
    logic [31:0]   qData [$];
    logic [31:0]   expOut [$];
    int            outstanding;
    bit            active;
    bit            pendingDone;
    bit            curWr;
    bit            wPhase;
    bit            expReq;
    bit            nextDone;
    logic [AW-1:0] a;
    bit            w;
    logic [31:0]   d;
    for (int i = 0; i < NW; i++) refMem[i] = seedWord(i);
    outstanding = 0;
    active      = 0;
    pendingDone = 0;
    curWr       = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        qAddr.delete();
        qWe.delete();
        qData.delete();
        expOut.delete();
        outstanding = 0;
        active      = 0;
        pendingDone = 0;
      end else begin
        wPhase = active && curWr && (qAddr.size() > 0);
        expReq = wPhase ? in_valid : (active && !curWr && (qAddr.size() > 0) && (outstanding < 2));
        checkOutput("done", done_o, pendingDone);
        checkOutput("busy", busy_o, active);
        checkOutput("cmd_ready", cmd_ready_o, !active);
        checkOutput("in_ready", in_ready_o, wPhase);
        checkOutput("out_valid", out_valid_o, outstanding > 0);
        checkOutput("sram_req", sram_if.req, expReq);
        nextDone = 0;
        if (sram_if.req && qAddr.size() > 0) begin
          a = qAddr.pop_front();
          w = qWe.pop_front();
          d = qData.pop_front();
          checkOutput("sram_addr", sram_if.addr, a);
          checkOutput("sram_we", sram_if.we, w);
          if (w) begin
            checkOutput("sram_wdata", sram_if.wdata, d);
            checkOutput("sram_be", sram_if.be, 32'hF);
            if (qAddr.size() == 0) nextDone = 1;
          end else begin
            outstanding++;
          end
        end
        if (out_valid_o && out_ready && expOut.size() > 0 && outstanding > 0) begin
          checkOutput("out_data", out_data_o, expOut.pop_front());
          outstanding--;
          if (expOut.size() == 0) nextDone = 1;
        end
        if (!active && cmd_valid) begin
          curWr  = cmd_write;
          active = 1;
          if (cmd_len == '0) nextDone = 1;
          for (int i = 0; i < int'(cmd_len); i++) begin
            a = AW'((int'(cmd_addr) + i) % NW);
            qAddr.push_back(a);
            qWe.push_back(cmd_write);
            if (cmd_write) begin
              qData.push_back(wdataArr[i]);
              refMem[a] = wdataArr[i];
            end else begin
              qData.push_back('0);
              expOut.push_back(refMem[a]);
            end
          end
        end else if (pendingDone) begin
          active = 0;
        end
        pendingDone = nextDone;
      end
    end
  end

  // Issue one command and feed its stream until done_o. Reports the
  // iteration (0 = first cycle after acceptance) of done_o and of the
  // first out_valid_o; read words that were handed over land in captured.
  task automatic applyStimulus(input bit wr, input int addr, input int len, input int mode,
                               input bit fixedData, input logic [31:0] base,
                               output int doneIter, output int firstValidIter);
    int beat;
    int k;
    int budget;
    captured.delete();
    for (int i = 0; i < len; i++) wdataArr[i] = fixedData ? base + 32'(i) : $urandom;
    doneIter       = -1;
    firstValidIter = -1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready_o && k < 50);
    if (!cmd_ready_o) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      return;
    end
    beat   = 0;
    budget = 30 * len + 40;
    for (k = 0; k < budget && doneIter < 0; k++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      in_valid  = wr && (beat < len) && pickReady(mode, k);
      in_data   = (beat < len) ? wdataArr[beat] : 32'd0;
      out_ready = !wr && pickReady(mode, k);
      @(negedge clk);
      if (in_valid && in_ready_o) beat++;
      if (out_valid_o && firstValidIter < 0) firstValidIter = k;
      if (out_valid_o && out_ready) captured.push_back(out_data_o);
      if (done_o) doneIter = k;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    if (doneIter < 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int dIter;
    int vIter;
    bit wr;
    int len;
    rst_ni    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready_o, 32'd1);
    checkOutput("rst_in_ready", in_ready_o, 32'd0);
    checkOutput("rst_out_valid", out_valid_o, 32'd0);
    checkOutput("rst_sram_req", sram_if.req, 32'd0);
    checkOutput("rst_sram_we", sram_if.we, 32'd0);
    checkOutput("rst_busy", busy_o, 32'd0);
    checkOutput("rst_done", done_o, 32'd0);
    #1 rst_ni = 1'b1;

    $display("[TB] write burst 0x10 len 4");
    applyStimulus(1'b1, 16, 4, 0, 1'b1, 32'hA0, dIter, vIter);
    checkOutput("wr_done_iter", dIter, 32'd4);
    checkOutput("wr_mem16", sramMem[16], 32'hA0);
    checkOutput("wr_mem17", sramMem[17], 32'hA1);
    checkOutput("wr_mem18", sramMem[18], 32'hA2);
    checkOutput("wr_mem19", sramMem[19], 32'hA3);

    $display("[TB] read burst with backpressure");
    applyStimulus(1'b0, 16, 4, 2, 1'b0, 32'h0, dIter, vIter);
    checkOutput("bp_count", captured.size(), 32'd4);
    for (int i = 0; i < 4 && i < captured.size(); i++) begin
      checkOutput("bp_word", captured[i], 32'hA0 + 32'(i));
    end

    $display("[TB] streaming read len 8");
    applyStimulus(1'b0, 16, 8, 0, 1'b0, 32'h0, dIter, vIter);
    checkOutput("stream_first_valid", vIter, 32'd1);
    checkOutput("stream_done_iter", dIter, 32'd9);
    checkOutput("stream_count", captured.size(), 32'd8);

    $display("[TB] wrap write at last address");
    applyStimulus(1'b1, NW - 1, 3, 0, 1'b1, 32'hC0, dIter, vIter);
    checkOutput("wrap_mem31", sramMem[31], 32'hC0);
    checkOutput("wrap_mem0", sramMem[0], 32'hC1);
    checkOutput("wrap_mem1", sramMem[1], 32'hC2);

    $display("[TB] zero length command");
    applyStimulus(1'b0, 7, 0, 0, 1'b0, 32'h0, dIter, vIter);
    checkOutput("zero_done_iter", dIter, 32'd0);
    @(negedge clk);
    checkOutput("zero_ready_after", cmd_ready_o, 32'd1);

    $display("[TB] reset abort during read");
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'd5;
    cmd_len   = 6'd8;
    out_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("abort_cmd_ready", cmd_ready_o, 32'd1);
    checkOutput("abort_busy", busy_o, 32'd0);
    checkOutput("abort_out_valid", out_valid_o, 32'd0);
    checkOutput("abort_sram_req", sram_if.req, 32'd0);
    checkOutput("abort_in_ready", in_ready_o, 32'd0);
    checkOutput("abort_done", done_o, 32'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_no_done", done_o, 32'd0);
    end
    #1 rst_ni = 1'b1;
    applyStimulus(1'b0, 5, 4, 1, 1'b0, 32'h0, dIter, vIter);
    checkOutput("abort_recover", dIter >= 0, 32'd1);

    $display("[TB] randomized commands");
    for (int n = 0; n < 40; n++) begin
      wr  = $urandom_range(0, 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NW) : $urandom_range(0, 6);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(wr, $urandom_range(0, NW - 1), len, wr ? $urandom_range(0, 1) : $urandom_range(0, 2),
                    1'b0, 32'h0, dIter, vIter);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
